// File: rtl/bcd4digit_ctrl_if.sv
// Handshake bundle between the BCD conversion sequencer and its environment.
// Signal prefixes are from the sequencer's point of view: i_ into it, o_ out of it.
interface bcd4digit_ctrl_if;
  logic        i_start;
  logic [13:0] i_value;
  logic        i_dp_done;
  logic        i_dp_carry;
  logic [13:0] o_dp_value;
  logic        o_load_value;
  logic        o_divide;
  logic        o_load_quotient;
  logic        o_busy;
  logic        o_conv_done;
  logic        o_err;

  modport master (
    output i_start, i_value, i_dp_done, i_dp_carry,
    input  o_dp_value, o_load_value, o_divide, o_load_quotient, o_busy, o_conv_done, o_err
  );

  modport slave (
    input  i_start, i_value, i_dp_done, i_dp_carry,
    output o_dp_value, o_load_value, o_divide, o_load_quotient, o_busy, o_conv_done, o_err
  );
endinterface

// File: rtl/bcd4digit_ctrl.sv
// bcd4digit_ctrl: sequencer for the repeated-subtraction divide-by-10 binary-to-BCD datapath.
// Optional macro AUTO_REFRESH_EN: self-triggered conversion every REFRESH_PERIOD idle cycles.
module bcd4digit_ctrl #(
  parameter int MAX_VALUE      = 9999,
  parameter int TIMEOUT        = 2047,
  parameter int TO_W           = 11,
  parameter int REFRESH_PERIOD = 50000,
  parameter int RF_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd4digit_ctrl_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  if (TO_W < $clog2(TIMEOUT + 1)) begin : g_to_w_check
    $error("TO_W too narrow for TIMEOUT");
  end
  if (RF_W < $clog2(REFRESH_PERIOD + 1)) begin : g_rf_w_check
    $error("RF_W too narrow for REFRESH_PERIOD");
  end

  logic [1:0]      r_state;
  logic [1:0]      w_state_next;
  logic [13:0]     r_dp_value;
  logic            r_err;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_req;
  logic            w_over;
  logic            w_accept;
  logic            w_err_set;
  logic            w_load_value;
  logic            w_divide;
  logic            w_load_quot;

`ifdef AUTO_REFRESH_EN
  logic [RF_W-1:0] r_rf_cnt;
  logic            w_rf_tick;

  assign w_rf_tick = (r_state == IDLE) && (r_rf_cnt == RF_W'(REFRESH_PERIOD - 1));
  assign w_req     = bus.i_start | w_rf_tick;

  // Free-runs only while idle; any request (external or its own tick) restarts the period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_cnt <= '0;
    end else if (r_state != IDLE || bus.i_start || w_rf_tick) begin
      r_rf_cnt <= '0;
    end else begin
      r_rf_cnt <= r_rf_cnt + RF_W'(1);
    end
  end
`else
  assign w_req = bus.i_start;
`endif

  assign w_over   = bus.i_value > 14'(MAX_VALUE);
  assign w_accept = (r_state == IDLE) && w_req && !w_over;

  always_comb begin
    w_state_next = r_state;
    w_err_set    = 1'b0;
    w_load_value = 1'b0;
    w_divide     = 1'b0;
    w_load_quot  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_over) w_err_set = 1'b1;
          else        w_state_next = LOAD;
        end
      end
      LOAD: begin
        w_load_value = 1'b1;
        w_state_next = RUN;
      end
      RUN: begin
        // Timeout wins over everything so a stuck datapath can never hold us in RUN.
        if (r_to_cnt == TO_W'(TIMEOUT)) begin
          w_err_set    = 1'b1;
          w_state_next = FIN;
        end else if (bus.i_dp_carry) begin
          w_load_quot = 1'b1;
          if (bus.i_dp_done) w_state_next = FIN;
        end else if (bus.i_dp_done) begin
          w_err_set    = 1'b1;
          w_state_next = FIN;
        end else begin
          w_divide = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_dp_value <= '0;
      r_err      <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) r_dp_value <= bus.i_value;
      if (w_accept)       r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
      if (r_state == RUN) r_to_cnt <= r_to_cnt + TO_W'(1);
      else                r_to_cnt <= '0;
    end
  end

  assign bus.o_dp_value      = r_dp_value;
  assign bus.o_load_value    = w_load_value;
  assign bus.o_divide        = w_divide;
  assign bus.o_load_quotient = w_load_quot;
  assign bus.o_busy          = (r_state == LOAD) || (r_state == RUN);
  assign bus.o_conv_done     = (r_state == FIN);
  assign bus.o_err           = r_err;
endmodule

// File: tb/tb_bcd4digit_ctrl.sv
// Scoreboard bench for bcd4digit_ctrl: a behavioural divide-by-10 datapath answers the strobes,
// stimulus pushes expected conversions, a monitor pops and checks them on each conv_done.
module tb_bcd4digit_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bcd4digit_ctrl_if bus();

  bcd4digit_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath: dividend, quotient, digit index, four digits (blank = F).
  logic [13:0] m_div = '0;
  logic [13:0] m_q   = '0;
  logic [1:0]  m_idx = '0;
  logic [3:0]  m_dig [4] = '{4'hF, 4'hF, 4'hF, 4'hF};

  assign bus.i_dp_carry = (m_div < 14'd10);
  assign bus.i_dp_done  = ((m_q == 14'd0) && (m_div < 14'd10)) || (m_idx == 2'd3);

  always @(posedge clk) begin
    if (bus.o_load_value) begin
      m_div <= bus.o_dp_value;
      m_q   <= '0;
      m_idx <= '0;
    end else if (bus.o_divide) begin
      m_div <= m_div - 14'd10;
      m_q   <= m_q + 14'd1;
    end else if (bus.o_load_quotient) begin
      m_dig[m_idx] <= m_div[3:0];
      m_div <= m_q;
      m_q   <= '0;
      m_idx <= m_idx + 2'd1;
    end
  end

  typedef struct {
    logic [15:0] digits;
    int          n_div;
    int          n_st;
    int          err;
    int          lat;
    int          start;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int viol = 0;
  int ld_total = 0;
  int n_div = 0;
  int n_st = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic [15:0] digits_now();
    return {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
  endfunction

  // Monitor: strobe legality every cycle, full comparison on every conv_done.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((int'(bus.o_load_value) + int'(bus.o_divide) + int'(bus.o_load_quotient)) > 1 ||
          (bus.o_divide && bus.i_dp_carry)) viol++;
      if (bus.o_load_value) begin
        n_div = 0;
        n_st  = 0;
        ld_total++;
      end
      if (bus.o_divide) n_div++;
      if (bus.o_load_quotient) n_st++;
      if (bus.o_conv_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_conv_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("digits", int'(digits_now()), int'(e.digits));
          chk("divides", n_div, e.n_div);
          chk("stores", n_st, e.n_st);
          chk("err_at_done", int'(bus.o_err), e.err);
          chk("latency", cyc - e.start, e.lat);
          $display("conv: digits=%h divides=%0d stores=%0d err=%0d latency=%0d",
                   digits_now(), n_div, n_st, bus.o_err, cyc - e.start);
        end
      end
    end
  end

  // Latency is counted from the cycle start is driven to the cycle conv_done is seen:
  // one LOAD cycle, one RUN cycle per strobe, then FIN.
  task automatic do_start(input logic [13:0] v, input bit push, input logic [15:0] dig,
                          input int nd, input int ns);
    exp_t e;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_value = v;
    if (push) begin
      e.digits = dig; e.n_div = nd; e.n_st = ns; e.err = 0;
      e.lat = 2 + nd + ns; e.start = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!bus.o_busy && !bus.o_conv_done) begin
        ok = 1;
        break;
      end
    end
    chk({nm, "_finished_in_budget"}, int'(ok), 1);
  endtask

  int ld_before;

  initial begin
    bus.i_start = 1'b0;
    bus.i_value = '0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", int'(bus.o_busy), 0);
    chk("rst_err", int'(bus.o_err), 0);
    chk("rst_dp_value", int'(bus.o_dp_value), 0);
    chk("rst_conv_done", int'(bus.o_conv_done), 0);
    chk("rst_strobes", int'(bus.o_load_value) + int'(bus.o_divide) + int'(bus.o_load_quotient), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-RUN aborts the conversion with no stores done yet
    do_start(14'd9999, 0, 16'h0, 0, 0);
    repeat (50) @(negedge clk);
    chk("midrun_busy_before", int'(bus.o_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy", int'(bus.o_busy), 0);
    chk("midrun_rst_strobes", int'(bus.o_load_value) + int'(bus.o_divide) + int'(bus.o_load_quotient), 0);
    chk("midrun_rst_err", int'(bus.o_err), 0);
    @(negedge clk);
    chk("midrun_next_busy", int'(bus.o_busy), 0);
    chk("midrun_next_done", int'(bus.o_conv_done), 0);
    chk("midrun_digits_kept", int'(digits_now()), 16'hFFFF);
    rst_n = 1'b1;
    @(negedge clk);

    // Value 0: single store of the ones digit
    do_start(14'd0, 1, 16'hFFF0, 0, 1);
    wait_idle("v0");

    // Value 25: two divides, two stores
    do_start(14'd25, 1, 16'hFF25, 2, 2);
    wait_idle("v25");

    // Value 9999 with a start during busy that must be dropped
    ld_before = ld_total;
    do_start(14'd9999, 1, 16'h9999, 1107, 4);
    repeat (10) @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_value = 14'd42;
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_idle("v9999");
    repeat (5) @(negedge clk);
    chk("busy_start_ignored", ld_total - ld_before, 1);

    // Out-of-range value is rejected without touching the datapath
    ld_before = ld_total;
    do_start(14'd10000, 0, 16'h0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reject_err", int'(bus.o_err), 1);
    chk("reject_busy", int'(bus.o_busy), 0);
    chk("reject_no_load", ld_total - ld_before, 0);
    chk("reject_digits", int'(digits_now()), 16'h9999);

    // Next accepted start clears err; upper digits keep the 9999 contents
    do_start(14'd42, 1, 16'h9942, 4, 2);
    chk("accept_clears_err", int'(bus.o_err), 0);
    wait_idle("v42");

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("strobe_rules", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
